multi_mode_game_counter: RTL and testbench
==========================================

Name: multi_mode_game_counter

Overview:
Parametrised successor of the team's multi-mode up/down game counter. A W-bit counter steps up or down by 1 or by a runtime step, with load, pause and optional saturation. Winner (all-ones) and loser (zero) hits are scored in SCORE_W-bit tallies, and a three-state game FSM freezes the game at a configurable limit until it is explicitly restarted. It sits between the control/stimulus logic and the score display/status logic.

Parameters:
W, 4, counter width (>=2)
SCORE_W, 4, width of winner/loser tallies
WIN_LIMIT, 15, tally value that ends the game (1 <= WIN_LIMIT <= 2^SCORE_W-1)
SATURATE, 0, 0 = counter wraps modulo 2^W; 1 = counter clamps at 0 / all-ones

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  leave IDLE and begin a game
en  in  1  count/score enable (0 = pause)
control  in  2  mode: 00 +1, 01 +step, 10 -1, 11 -step
step  in  W  step magnitude for modes 01/11
init  in  1  synchronous load of load_data
load_data  in  W  value loaded on init
restart  in  1  acknowledge game over; return to IDLE
counter  out  W  current count
winner  out  1  registered all-ones hit flag
loser  out  1  registered zero hit flag
winner_count  out  SCORE_W  winner tally
loser_count  out  SCORE_W  loser tally
game_over  out  1  high while in OVER (decoded from state)
who  out  2  10 = winner reached limit, 01 = loser reached limit, 00 = none

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, winner=loser=0, both tallies=0, who=00, game_over=0.
- IDLE: everything holds. On start=1: next state RUN; counter <= 0 if control[1]=0, else all-ones. Tallies and flags are not altered.
- RUN, per cycle, in priority order: init=1 -> counter <= load_data; else en=1 -> counter updates per control; else counter holds.
- Arithmetic is in W bits. SATURATE=0: wrap (e.g. W=4: 14+3 -> 1, 1-3 -> 14). SATURATE=1: result clamped to [0, 2^W-1]. step=0 in modes 01/11 holds the value.
- Scoring in RUN when en=1 (init does not block it) uses the registered counter value:
  - counter==0: loser<=1, winner<=0, loser_count+1.
  - counter==all-ones: winner<=1, loser<=0, winner_count+1.
  - otherwise: both flags 0.
  - When en=0: both flags 0 and tallies hold.
  - Flag latency: one cycle after counter shows 0 or all-ones.
- Game end: the cycle a tally increments to WIN_LIMIT, next state is OVER; who is latched to 10 (winner) or 01 (loser). Both tallies cannot increment in one cycle.
- OVER:
  - counter, tallies and who are frozen; winner/loser flags clear to 0.
  - init, en and start are ignored; game_over=1.
  - On restart=1: counter=0, tallies=0, flags=0, who=00, next state IDLE.
- restart outside OVER is ignored. start outside IDLE is ignored.
- Asynchronous reset mid-game (any state) returns immediately to reset values.
- Invalid state encodings recover to IDLE.

Decomposition:
- Package multi_mode_game_counter_pkg:
  - state enum (IDLE, RUN, OVER);
  - mode constants (MODE_INC1, MODE_INCS, MODE_DEC1, MODE_DECS);
  - who encodings (WHO_NONE=00, WHO_LOSER=01, WHO_WINNER=10).
- One sub-module, mmgc_score_counter: a SCORE_W tally with sync clear, increment enable and a hit_limit output (WIN_LIMIT parameter). It is instantiated twice, once for winner and once for loser.

Test Plan:
- W=4, SATURATE=0: reset, start with control=01, step=3, en=1 -> counter 0,3,6,9,12,15,2; loser=1 one cycle after 0; winner=1 one cycle after 15; tallies 1/1.
- SATURATE=1, W=4: init with load_data=14, then control=01, step=3 -> counter 15 and holds; winner_count increments every cycle; with WIN_LIMIT=3, game_over is asserted and who=10 after the 3rd hit.
- WIN_LIMIT=2, control=10 from 1 -> counter 0; loser hits accumulate; game_over=1, who=01; counter/tallies frozen despite en=1 and init=1 -> restart -> all zero, IDLE; start with control=10 -> counter=all-ones.
- Pause: en=0 while counter=0 for 5 cycles -> loser stays 0, loser_count unchanged, counter holds; en=1 -> scoring resumes the next cycle.
- rst pulsed mid-RUN and during OVER -> all outputs immediately at reset values; start and restart ignored in the wrong state (no state change).

Source files
------------

// File: rtl/multi_mode_game_counter_pkg.sv
// Shared types and encodings for the multi-mode game counter:
// game states, counting modes and the game-over "who" code.
package multi_mode_game_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [1:0] MODE_INC1 = 2'b00;
  localparam logic [1:0] MODE_INCS = 2'b01;
  localparam logic [1:0] MODE_DEC1 = 2'b10;
  localparam logic [1:0] MODE_DECS = 2'b11;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

endpackage

// File: rtl/mmgc_score_counter.sv
// Score tally with synchronous clear and increment enable. hit_limit flags
// the cycle in which the pending increment takes the tally to WIN_LIMIT.
module mmgc_score_counter
  import multi_mode_game_counter_pkg::*;
#(
  parameter int SCORE_W   = 4,
  parameter int WIN_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count,
  output logic               hit_limit
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + SCORE_W'(1);
  end

  assign hit_limit = inc && (count == SCORE_W'(WIN_LIMIT - 1));

endmodule

// File: rtl/multi_mode_game_counter.sv
// Up/down game counter with step/load/pause, optional saturation, winner and
// loser tallies, and an IDLE/RUN/OVER game FSM that freezes at the limit.
module multi_mode_game_counter
  import multi_mode_game_counter_pkg::*;
#(
  parameter int W         = 4,
  parameter int SCORE_W   = 4,
  parameter int WIN_LIMIT = 15,
  parameter int SATURATE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               en,
  input  logic [1:0]         control,
  input  logic [W-1:0]       step,
  input  logic               init,
  input  logic [W-1:0]       load_data,
  input  logic               restart,
  output logic [W-1:0]       counter,
  output logic               winner,
  output logic               loser,
  output logic [SCORE_W-1:0] winner_count,
  output logic [SCORE_W-1:0] loser_count,
  output logic               game_over,
  output logic [1:0]         who
);

  state_t         state, state_nx;
  logic [W-1:0]   step_amt, arith;
  logic [W:0]     sum, diff;
  logic           count_up, scoring, win_inc, lose_inc, win_hit, lose_hit, clear_all;

  // W+1-bit sum/difference: the extra bit is the carry/borrow used to clamp.
  always_comb begin
    count_up = (control == MODE_INC1) || (control == MODE_INCS);
    step_amt = ((control == MODE_INCS) || (control == MODE_DECS)) ? step : W'(1);
    sum      = {1'b0, counter} + {1'b0, step_amt};
    diff     = {1'b0, counter} - {1'b0, step_amt};
    if (count_up) arith = (SATURATE != 0 && sum[W])  ? '1 : sum[W-1:0];
    else          arith = (SATURATE != 0 && diff[W]) ? '0 : diff[W-1:0];
  end

  assign scoring   = (state == RUN) && en;
  assign win_inc   = scoring && (counter == '1);
  assign lose_inc  = scoring && (counter == '0);
  assign clear_all = (state == OVER) && restart;
  assign game_over = (state == OVER);

  mmgc_score_counter #(.SCORE_W(SCORE_W), .WIN_LIMIT(WIN_LIMIT)) u_win (
    .clk(clk), .rst(rst), .clr(clear_all), .inc(win_inc),
    .count(winner_count), .hit_limit(win_hit)
  );

  mmgc_score_counter #(.SCORE_W(SCORE_W), .WIN_LIMIT(WIN_LIMIT)) u_lose (
    .clk(clk), .rst(rst), .clr(clear_all), .inc(lose_inc),
    .count(loser_count), .hit_limit(lose_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: next state defaults to the current state first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (win_hit || lose_hit) state_nx = OVER;
      OVER:    if (restart) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      winner  <= 1'b0;
      loser   <= 1'b0;
      who     <= WHO_NONE;
    end else begin
      case (state)
        IDLE: if (start) counter <= control[1] ? '1 : '0;
        RUN: begin
          if (init)    counter <= load_data;
          else if (en) counter <= arith;
          winner <= win_inc;
          loser  <= lose_inc;
          if (win_hit)       who <= WHO_WINNER;
          else if (lose_hit) who <= WHO_LOSER;
        end
        OVER: begin
          winner <= 1'b0;
          loser  <= 1'b0;
          if (restart) begin
            counter <= '0;
            who     <= WHO_NONE;
          end
        end
        default: begin
          winner <= 1'b0;
          loser  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_mode_game_counter.sv
// Directed bench for multi_mode_game_counter: three instances (wrap/limit 15,
// saturate/limit 3, wrap/limit 2) share stimulus; each phase checks one.
module tb_multi_mode_game_counter;

  typedef struct packed {
    logic [3:0] counter;
    logic       winner;
    logic       loser;
    logic [3:0] wc;
    logic [3:0] lc;
    logic       game_over;
    logic [1:0] who;
  } out_t;

  typedef struct packed {
    logic       start;
    logic       en;
    logic       init;
    logic       restart;
    logic [1:0] control;
    logic [3:0] step;
    logic [3:0] load_data;
  } in_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, en = 1'b0, init = 1'b0, restart = 1'b0;
  logic [1:0] control = 2'b00;
  logic [3:0] step = 4'd0, load_data = 4'd0;
  out_t       obs [3];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SAT = (g == 1) ? 1 : 0;
    localparam int WL  = (g == 0) ? 15 : (g == 1) ? 3 : 2;
    logic [3:0] c, wc, lc;
    logic       w, l, go;
    logic [1:0] wh;
    multi_mode_game_counter #(.W(4), .SCORE_W(4), .WIN_LIMIT(WL), .SATURATE(SAT)) u_dut (
      .clk(clk), .rst(rst), .start(start), .en(en), .control(control), .step(step),
      .init(init), .load_data(load_data), .restart(restart), .counter(c),
      .winner(w), .loser(l), .winner_count(wc), .loser_count(lc),
      .game_over(go), .who(wh)
    );
    assign obs[g] = {c, w, l, wc, lc, go, wh};
  end

  function automatic in_t mi(logic s, logic e, logic it, logic rs, logic [1:0] c,
                             logic [3:0] st, logic [3:0] ld);
    return '{start: s, en: e, init: it, restart: rs, control: c, step: st, load_data: ld};
  endfunction

  function automatic out_t mo(logic [3:0] c, logic w, logic l, logic [3:0] wc,
                              logic [3:0] lc, logic go, logic [1:0] wh);
    return '{counter: c, winner: w, loser: l, wc: wc, lc: lc, game_over: go, who: wh};
  endfunction

  task automatic check(string name, int d, out_t exp);
    out_t act;
    act = obs[d];
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got cnt=%0d w=%b l=%b wc=%0d lc=%0d go=%b who=%b, want cnt=%0d w=%b l=%b wc=%0d lc=%0d go=%b who=%b",
               name, d, act.counter, act.winner, act.loser, act.wc, act.lc, act.game_over, act.who,
               exp.counter, exp.winner, exp.loser, exp.wc, exp.lc, exp.game_over, exp.who);
    end
  endtask

  // Drive inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic step_chk(string name, int d, in_t v, out_t exp);
    start = v.start; en = v.en; init = v.init; restart = v.restart;
    control = v.control; step = v.step; load_data = v.load_data;
    @(posedge clk);
    #1;
    check(name, d, exp);
  endtask

  // Asynchronous reset pulse between clock edges; checks all three instances.
  task automatic async_reset(string name);
    start = 1'b0; en = 1'b0; init = 1'b0; restart = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check(name, d, '0);
    #1 rst = 1'b0;
  endtask

  vec_t tbl [18];

  initial begin
    // Wrap instance (dut0): step count, wrap both ways, init priority, hold cases.
    tbl[0]  = '{mi(1,0,0,0,2'b01,4'd3,4'd0), mo(4'd0, 0,0,4'd0,4'd0,0,2'b00)};
    tbl[1]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd3, 0,1,4'd0,4'd1,0,2'b00)};
    tbl[2]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd6, 0,0,4'd0,4'd1,0,2'b00)};
    tbl[3]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd9, 0,0,4'd0,4'd1,0,2'b00)};
    tbl[4]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd12,0,0,4'd0,4'd1,0,2'b00)};
    tbl[5]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd15,0,0,4'd0,4'd1,0,2'b00)};
    tbl[6]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd2, 1,0,4'd1,4'd1,0,2'b00)};
    tbl[7]  = '{mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd5, 0,0,4'd1,4'd1,0,2'b00)};
    tbl[8]  = '{mi(0,1,0,0,2'b11,4'd3,4'd0), mo(4'd2, 0,0,4'd1,4'd1,0,2'b00)};
    tbl[9]  = '{mi(0,1,0,0,2'b11,4'd3,4'd0), mo(4'd15,0,0,4'd1,4'd1,0,2'b00)};
    tbl[10] = '{mi(0,1,0,0,2'b11,4'd3,4'd0), mo(4'd12,1,0,4'd2,4'd1,0,2'b00)};
    tbl[11] = '{mi(0,1,1,0,2'b11,4'd3,4'd0), mo(4'd0, 0,0,4'd2,4'd1,0,2'b00)};
    tbl[12] = '{mi(0,1,1,0,2'b11,4'd3,4'd7), mo(4'd7, 0,1,4'd2,4'd2,0,2'b00)};
    tbl[13] = '{mi(0,0,0,0,2'b11,4'd3,4'd0), mo(4'd7, 0,0,4'd2,4'd2,0,2'b00)};
    tbl[14] = '{mi(0,1,0,0,2'b00,4'd3,4'd0), mo(4'd8, 0,0,4'd2,4'd2,0,2'b00)};
    tbl[15] = '{mi(0,1,0,0,2'b10,4'd3,4'd0), mo(4'd7, 0,0,4'd2,4'd2,0,2'b00)};
    tbl[16] = '{mi(0,1,0,0,2'b01,4'd0,4'd0), mo(4'd7, 0,0,4'd2,4'd2,0,2'b00)};
    tbl[17] = '{mi(1,0,0,0,2'b00,4'd3,4'd0), mo(4'd7, 0,0,4'd2,4'd2,0,2'b00)};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check("reset", d, '0);
    #2 rst = 1'b0;

    for (int k = 0; k < 18; k++) step_chk($sformatf("vec%0d", k), 0, tbl[k].i, tbl[k].o);

    // Pause at zero, resume scoring, then async reset mid-RUN.
    async_reset("rst_run_a");
    step_chk("pause_start", 0, mi(1,0,0,0,2'b01,4'd3,4'd0), mo(4'd0,0,0,4'd0,4'd0,0,2'b00));
    for (int k = 0; k < 5; k++)
      step_chk($sformatf("pause%0d", k), 0, mi(0,0,0,0,2'b01,4'd3,4'd0), mo(4'd0,0,0,4'd0,4'd0,0,2'b00));
    step_chk("resume", 0, mi(0,1,0,0,2'b01,4'd0,4'd0), mo(4'd0,0,1,4'd0,4'd1,0,2'b00));
    step_chk("resume2", 0, mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd3,0,1,4'd0,4'd2,0,2'b00));
    async_reset("rst_run_b");

    // Saturating instance (dut1, limit 3): clamp high, winner game end, reset in OVER.
    step_chk("sat_start", 1, mi(1,0,0,0,2'b01,4'd3,4'd0), mo(4'd0, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("sat_load",  1, mi(0,0,1,0,2'b01,4'd3,4'd14),mo(4'd14,0,0,4'd0,4'd0,0,2'b00));
    step_chk("sat_clamp", 1, mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd15,0,0,4'd0,4'd0,0,2'b00));
    step_chk("sat_win1",  1, mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd15,1,0,4'd1,4'd0,0,2'b00));
    step_chk("sat_win2",  1, mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd15,1,0,4'd2,4'd0,0,2'b00));
    step_chk("sat_win3",  1, mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd15,1,0,4'd3,4'd0,1,2'b10));
    step_chk("sat_frz",   1, mi(1,1,1,0,2'b01,4'd3,4'd5), mo(4'd15,0,0,4'd3,4'd0,1,2'b10));
    async_reset("rst_over");
    step_chk("sat_dstart",1, mi(1,0,0,0,2'b11,4'd3,4'd0), mo(4'd15,0,0,4'd0,4'd0,0,2'b00));
    step_chk("sat_dload", 1, mi(0,0,1,0,2'b11,4'd3,4'd2), mo(4'd2, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("sat_clamp0",1, mi(0,1,0,0,2'b11,4'd3,4'd0), mo(4'd0, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("sat_hold0", 1, mi(0,1,0,0,2'b10,4'd3,4'd0), mo(4'd0, 0,1,4'd0,4'd1,0,2'b00));

    // Limit-2 instance (dut2): loser game end, freeze, restart, wrong-state controls.
    async_reset("rst_l2");
    step_chk("l2_start",  2, mi(1,0,0,0,2'b10,4'd0,4'd0), mo(4'd15,0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_load",   2, mi(0,0,1,0,2'b10,4'd0,4'd1), mo(4'd1, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_dec",    2, mi(0,1,0,0,2'b10,4'd0,4'd0), mo(4'd0, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_lose1",  2, mi(0,1,0,0,2'b11,4'd0,4'd0), mo(4'd0, 0,1,4'd0,4'd1,0,2'b00));
    step_chk("l2_lose2",  2, mi(0,1,0,0,2'b11,4'd0,4'd0), mo(4'd0, 0,1,4'd0,4'd2,1,2'b01));
    step_chk("l2_frz",    2, mi(1,1,1,0,2'b01,4'd3,4'd9), mo(4'd0, 0,0,4'd0,4'd2,1,2'b01));
    step_chk("l2_restart",2, mi(0,0,0,1,2'b01,4'd3,4'd0), mo(4'd0, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_idle",   2, mi(0,1,0,0,2'b01,4'd3,4'd0), mo(4'd0, 0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_start2", 2, mi(1,0,0,0,2'b10,4'd3,4'd0), mo(4'd15,0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_rs_run", 2, mi(0,0,0,1,2'b10,4'd3,4'd0), mo(4'd15,0,0,4'd0,4'd0,0,2'b00));
    step_chk("l2_run",    2, mi(0,1,0,0,2'b10,4'd3,4'd0), mo(4'd14,1,0,4'd1,4'd0,0,2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
